// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, counter width,
// and the load-use hazard detector.
package pipe_ctrl_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush   = 2'd1,
        StMemWait = 2'd2,
        StUnused  = 2'd3
    } state_e;

    // A load in EX whose result is needed by the instruction in ID; x0 never hazards.
    function automatic logic is_load_use(input logic [4:0] id_rs1,
                                         input logic [4:0] id_rs2,
                                         input logic       id_rs2_used,
                                         input logic [4:0] ex_rd,
                                         input logic       ex_we,
                                         input logic       ex_is_load);
        return ex_is_load && ex_we && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_rs2_used && (ex_rd == id_rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clear,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: stalls, bubbles and flushes for load-use,
// taken branches and slow memory, plus stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_we,
    input  logic             ex_is_load,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    state_e state_q, state_d;
    logic   load_use;

    assign load_use = is_load_use(id_rs1, id_rs2, id_rs2_used, ex_rd, ex_we, ex_is_load);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        state_d     = StRun;

        if (!reset) begin
            // Keep the pipe moving so it fills with bubbles while held in reset.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            state_d     = StMemWait;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = StFlush;
        end else if (state_q == StFlush) begin
            // Drop the word the synchronous IMEM fetched before the redirect landed.
            ifid_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign state = state_q;

    sat_counter #(
        .Width(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .inc  (~pc_en),
        .clear(~reset),
        .count(stall_cnt)
    );

    sat_counter #(
        .Width(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .inc  (ifid_flush),
        .clear(~reset),
        .count(flush_cnt)
    );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port: id_rs1, id_rs2  input  5 each  source register fields of the instruction in ID.
REQ-004 SHALL have port: id_rs2_used  input  1  ID instruction reads rs2 (R-type, store, branch).
REQ-005 SHALL have port: ex_rd  input  5  destination of the instruction in EX.
REQ-006 SHALL have port: ex_we, ex_is_load  input  1 each  EX register-file write enable; EX instruction is a load.
REQ-007 SHALL have port: branch_taken  input  1  EX resolved a taken branch/jump this cycle.
REQ-008 SHALL have port: mem_busy  input  1  MEM-stage data access not complete this cycle.
REQ-009 SHALL have port: pc_en, ifid_en, idex_en, exmem_en  output  1 each  pipeline register load enables (1 = advance).
REQ-010 SHALL have port: ifid_flush, idex_flush, memwb_flush  output  1 each  load a bubble (NOP, all control zero) into that register.
REQ-011 SHALL have port: stall_cnt, flush_cnt  output  16 each  saturating performance counters.
REQ-012 SHALL have port: state  output  2  current FSM state, debug only.

Function
REQ-013 SHALL implement FSM states RUN=0, FLUSH=1, MEM_WAIT=2; encoding 3 unused, SHALL return to RUN next cycle.
REQ-014 SHALL define load_use = ex_is_load & ex_we & (ex_rd!=0) & (ex_rd==id_rs1 | (id_rs2_used & ex_rd==id_rs2)).
REQ-015 Priority each cycle SHALL be mem_busy > branch_taken > FLUSH state > load_use > normal.
REQ-016 mem_busy=1 (any state): all four enables 0, all flushes 0 except memwb_flush=1; next state MEM_WAIT; no branch/load-use action taken.
REQ-017 MEM_WAIT with mem_busy=0: treated exactly as RUN for that cycle (branch_taken pending in EX is acted on now).
REQ-018 branch_taken=1, mem_busy=0: all enables 1, ifid_flush=1, idex_flush=1; next state FLUSH.
REQ-019 FLUSH, mem_busy=0, branch_taken=0: all enables 1, ifid_flush=1 (discards word from synchronous IMEM fetched before redirect); next state RUN.
REQ-020 RUN/MEM_WAIT, load_use=1, no higher event: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1; next state RUN; bubble lasts exactly one cycle.
REQ-021 Normal: all enables 1, all flushes 0, next state RUN.
REQ-022 Outputs other than stall_cnt, flush_cnt, state SHALL be combinational from state and inputs; zero-cycle latency.
REQ-023 stall_cnt SHALL increment on each cycle with pc_en=0; flush_cnt on each cycle with ifid_flush=1; both saturate at 0xFFFF.
REQ-024 Flush SHALL never be asserted on a register whose enable is 0.

Reset
REQ-025 reset=0 at a clock edge SHALL force state=RUN, stall_cnt=0, flush_cnt=0, regardless of current state (including mid-FLUSH or MEM_WAIT).
REQ-026 While reset=0, combinational outputs SHALL be: all enables 1, ifid_flush=1, idex_flush=1, memwb_flush=1 (pipeline fills with bubbles).

Structure
REQ-027 State encodings and counter width (CNT_W=16) SHALL live in shared package pipe_ctrl_pkg.
REQ-028 Both counters SHALL be instances of one sub-module sat_counter (parameter width, inputs inc, clear).

Verification
REQ-029 ex_is_load=1, ex_we=1, ex_rd=5, id_rs1=5 -> pc_en=0, ifid_en=0, idex_flush=1 one cycle; stall_cnt 0->1.
REQ-030 Same as REQ-029 with ex_rd=0 -> no stall; all enables 1, stall_cnt unchanged.
REQ-031 branch_taken=1 for 1 cycle from RUN -> cycle t: ifid_flush=idex_flush=1; t+1: ifid_flush=1, state FLUSH->RUN; flush_cnt +2.
REQ-032 mem_busy=1 for 3 cycles with branch_taken=1 held -> 3 cycles all enables 0, memwb_flush=1; 4th cycle branch flush per REQ-018.
REQ-033 branch_taken=1 and load_use=1 same cycle -> branch response only, pc_en=1.
REQ-034 reset=0 asserted while state=FLUSH and counters at 0xFFFF -> next edge state=RUN, counters 0.
